tt_um_uabc_pwm_multi: RTL and testbench

//  Tiny Tapeout top: N_CH-channel PWM generator, host-loaded via the dedicated inputs.
//  Per-channel 8-bit duty written through ui_in/uio_in; edge- or center-aligned mode; 4-step prescaler.

---
 rtl/tt_um_uabc_pwm_multi.sv | 167 ++++++++++++++++
 tb/tb_tt_um_uabc_pwm_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_uabc_pwm_multi.sv
// Multi-channel PWM generator for Tiny Tapeout: host-loaded 8-bit duties,
// edge/center-aligned shared counter, 4-step prescaler, double-buffered duty.
module tt_um_uabc_pwm_multi #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    // Two-flop synchronisers for both host buses, plus a third stage on the strobe.
    logic [7:0] ui_s1_q, ui_s2_q;
    logic [7:0] dat_s1_q, dat_s2_q;
    logic       stb_s3_q;

    logic [7:0]       shadow_q   [N_CH];
    logic [CNT_W-1:0] duty_act_q [N_CH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       sel_q, sel_d;
    logic [5:0]       pre_q, pre_d, pre_max;
    logic [N_CH-1:0]  uo_q, pwm_d;

    logic       write_pulse;
    logic [2:0] addr_s;
    logic       run_s;
    mode_e      mode_s;
    logic [1:0] sel_s;
    logic       tick;
    logic       period_start;
    logic       load_act;

    logic unused_ena;
    assign unused_ena = ena;

    assign write_pulse = ui_s2_q[3] & ~stb_s3_q;
    assign addr_s      = ui_s2_q[2:0];
    assign run_s       = ui_s2_q[4];
    assign mode_s      = mode_e'(ui_s2_q[5]);
    assign sel_s       = ui_s2_q[7:6];

    always_comb begin
        case (sel_q)
            2'd0:    pre_max = 6'd0;
            2'd1:    pre_max = 6'd3;
            2'd2:    pre_max = 6'd15;
            default: pre_max = 6'd63;
        endcase
    end

    assign tick         = run_s && (pre_q == pre_max);
    assign period_start = tick && (cnt_q == '0) && (dir_q == DIR_UP);
    // While stopped everything tracks the host, so a restart begins a clean period.
    assign load_act     = !run_s || period_start;

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = load_act ? mode_s : mode_q;
        sel_d  = load_act ? sel_s  : sel_q;

        if (!run_s) begin
            pre_d = '0;
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            pre_d = tick ? 6'd0 : pre_q + 6'd1;
            if (tick) begin
                if (mode_d == MODE_EDGE) begin
                    cnt_d = cnt_q + 1'b1;
                    dir_d = DIR_UP;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == MAX) begin
                        cnt_d = MAX - 1'b1;
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        dir_d = DIR_UP;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pwm_d[i] = run_s && (cnt_q < duty_act_q[i]);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; this is what makes a same-edge write load the old shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ui_s1_q  <= '0;
            ui_s2_q  <= '0;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
            stb_s3_q <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= MODE_EDGE;
            sel_q    <= '0;
            pre_q    <= '0;
            uo_q     <= '0;
            // NOTE: duty storage is a handful of flops, not a RAM, so it is
            // cleared by reset like any other state.
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i]   <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            ui_s1_q  <= ui_in;
            ui_s2_q  <= ui_s1_q;
            dat_s1_q <= uio_in;
            dat_s2_q <= dat_s1_q;
            stb_s3_q <= ui_s2_q[3];
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            pre_q    <= pre_d;
            uo_q     <= pwm_d;
            for (int i = 0; i < N_CH; i++) begin
                if (write_pulse && (addr_s == 3'(i))) begin
                    shadow_q[i] <= dat_s2_q;
                end
                if (load_act) begin
                    duty_act_q[i] <= CNT_W'(shadow_q[i]) << (CNT_W - 8);
                end
            end
        end
    end

    always_comb begin
        uo_out             = '0;
        uo_out[N_CH-1:0]   = uo_q;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_uabc_pwm_multi.sv
// Directed bench for tt_um_uabc_pwm_multi (N_CH=4, CNT_W=8): measures pulse
// high/low lengths in clocks at negedges and compares with hand-computed values.
module tb_tt_um_uabc_pwm_multi;

    localparam int  N_CH  = 4;
    localparam int  CNT_W = 8;
    localparam int  LIMIT = 5000;
    localparam time TCLK  = 10;

    logic       clk, rst_n, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    logic [1:0] sel_r;
    logic       mode_r, run_r, stb_r;
    logic [2:0] addr_r;
    logic       rand_en;
    logic [7:0] rand_v;

    int   n_checks, n_err;
    logic stray, timed_out;

    typedef struct {
        logic [1:0] sel;
        logic       mode;
        int         ch;
        logic [7:0] duty;
        int         hi;
        int         lo;
    } vec_t;

    vec_t vecs[7];

    assign ui_in = rand_en ? rand_v : {sel_r, mode_r, run_r, stb_r, addr_r};

    tt_um_uabc_pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #(TCLK/2) clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr_r = a;
        uio_in = d;
        stb_r  = 1'b1;
        cyc(4);
        stb_r  = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        check("reset uo_out", int'(uo_out), 0);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Waits (bounded) for uo_out[ch]==lvl; n = negedges consumed, t = time seen.
    task automatic wait_level(input int ch, input logic lvl, output int n, output time t);
        logic done;
        done = 1'b0;
        n = 0;
        t = 0;
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
            if ((uo_out & ~(8'd1 << ch)) != 8'd0) stray = 1'b1;
            if (uo_out[ch] == lvl) begin
                done = 1'b1;
                t = $time;
            end
        end
        if (!done) timed_out = 1'b1;
    endtask

    // Skips the first (possibly partial) pulse, then times one full high and low run.
    task automatic measure(input int ch, output int hi, output int lo);
        int  n;
        time t0, t1, t2;
        timed_out = 1'b0;
        wait_level(ch, 1'b0, n, t0);
        wait_level(ch, 1'b1, n, t0);
        wait_level(ch, 1'b0, n, t0);
        wait_level(ch, 1'b1, n, t0);
        wait_level(ch, 1'b0, n, t1);
        wait_level(ch, 1'b1, n, t2);
        hi = timed_out ? -1 : int'((t1 - t0) / TCLK);
        lo = timed_out ? -1 : int'((t2 - t1) / TCLK);
    endtask

    initial begin
        int  hi, lo, n, highs;
        time tr, tf;

        n_checks = 0;
        n_err    = 0;
        stray    = 1'b0;
        ena      = 1'b1;
        sel_r    = 2'd0;
        mode_r   = 1'b0;
        run_r    = 1'b0;
        stb_r    = 1'b0;
        addr_r   = 3'd0;
        uio_in   = 8'd0;
        rst_n    = 1'b0;

        // T1: reset with random inputs on both buses.
        rand_en = 1'b1;
        rand_v  = 8'($urandom);
        uio_in  = 8'($urandom);
        cyc(2);
        check("T1 uo_out", int'(uo_out), 0);
        check("T1 uio_out", int'(uio_out), 0);
        check("T1 uio_oe", int'(uio_oe), 0);
        rand_en = 1'b0;
        uio_in  = 8'd0;
        rst_n   = 1'b1;
        cyc(2);

        // sel, mode, ch, duty, expected high clocks, expected low clocks
        vecs[0] = '{2'd0, 1'b0, 2, 8'h40,   64,  192};
        vecs[1] = '{2'd0, 1'b0, 0, 8'hFF,  255,    1};
        vecs[2] = '{2'd0, 1'b1, 1, 8'h80,  255,  255};
        vecs[3] = '{2'd1, 1'b1, 3, 8'h80, 1020, 1020};
        vecs[4] = '{2'd1, 1'b0, 1, 8'h10,   64,  960};
        vecs[5] = '{2'd0, 1'b1, 0, 8'h01,    1,  509};
        vecs[6] = '{2'd2, 1'b0, 3, 8'h02,   32, 4064};

        foreach (vecs[i]) begin
            do_reset();
            run_r  = 1'b0;
            sel_r  = vecs[i].sel;
            mode_r = vecs[i].mode;
            wr(3'(vecs[i].ch), vecs[i].duty);
            run_r  = 1'b1;
            stray  = 1'b0;
            measure(vecs[i].ch, hi, lo);
            check($sformatf("vec%0d high", i), hi, vecs[i].hi);
            check($sformatf("vec%0d low", i), lo, vecs[i].lo);
            check($sformatf("vec%0d other channels", i), int'(stray), 0);
        end

        // T3: duty 0 keeps the channel low all period long.
        do_reset();
        run_r = 1'b0;
        sel_r = 2'd0;
        mode_r = 1'b0;
        wr(3'd0, 8'h00);
        run_r = 1'b1;
        highs = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            highs += int'(uo_out != 8'd0);
        end
        check("T3 duty0 high clocks", highs, 0);

        // T5: rewrite ch1 while its pulse is high; addr 7 is outside N_CH.
        do_reset();
        run_r = 1'b0;
        wr(3'd1, 8'h10);
        run_r = 1'b1;
        stray = 1'b0;
        timed_out = 1'b0;
        wait_level(1, 1'b1, n, tr);
        check("T5 run-to-rise clocks", n, 3);
        wr(3'd1, 8'hC0);
        wait_level(1, 1'b0, n, tf);
        check("T5 current period high", timed_out ? -1 : int'((tf - tr) / TCLK), 16);
        wr(3'd7, 8'hFF);
        timed_out = 1'b0;
        wait_level(1, 1'b1, n, tr);
        wait_level(1, 1'b0, n, tf);
        check("T5 next period high", timed_out ? -1 : int'((tf - tr) / TCLK), 192);
        wait_level(1, 1'b1, n, tr);
        check("T5 next period low", timed_out ? -1 : int'((tr - tf) / TCLK), 64);
        check("T5 addr7 ignored", int'(stray), 0);

        // T6a: run dropped mid-high, then restarted from cnt=0.
        do_reset();
        run_r = 1'b0;
        wr(3'd2, 8'h40);
        run_r = 1'b1;
        timed_out = 1'b0;
        wait_level(2, 1'b1, n, tr);
        cyc(5);
        run_r = 1'b0;
        cyc(2);
        check("T6 still high before sync", int'(uo_out[2]), 1);
        cyc(1);
        check("T6 run=0 uo_out", int'(uo_out), 0);
        cyc(20);
        check("T6 run=0 stays low", int'(uo_out), 0);
        run_r = 1'b1;
        wait_level(2, 1'b1, n, tr);
        check("T6 restart run-to-rise", n, 3);
        wait_level(2, 1'b0, n, tf);
        check("T6 restart first high", timed_out ? -1 : int'((tf - tr) / TCLK), 64);

        // T6b: reset mid-high clears output on the next edge.
        wait_level(2, 1'b1, n, tr);
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        check("T6 reset mid-high uo_out", int'(uo_out), 0);
        cyc(1);
        run_r = 1'b0;
        rst_n = 1'b1;
        cyc(1);
        wr(3'd2, 8'h40);
        run_r = 1'b1;
        timed_out = 1'b0;
        wait_level(2, 1'b1, n, tr);
        check("T6 post-reset run-to-rise", n, 3);
        wait_level(2, 1'b0, n, tf);
        check("T6 post-reset first high", timed_out ? -1 : int'((tf - tr) / TCLK), 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
